// File: rtl/tpu_mem_if.sv
// tpu_mem_if: TPU memory port between an initiator (master) and a scratchpad responder (slave)
interface tpu_mem_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_read;
    logic                  mem_write;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  mem_ready;
    modport master (output mem_addr, mem_read, mem_write, mem_wdata, input mem_rdata, mem_ready);
    modport slave  (input mem_addr, mem_read, mem_write, mem_wdata, output mem_rdata, mem_ready);
endinterface

// File: rtl/tpu_mem_responder.sv
// tpu_mem_responder: word-addressed scratchpad responder with wait states, error flagging and beat counters
module tpu_mem_responder #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DEPTH      = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h1000_0000,
    parameter int                    LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    tpu_mem_if.slave              bus,
    input  logic                  err_clr,
    output logic                  err,
    output logic [ADDR_WIDTH-1:0] err_addr,
    output logic [31:0]           rd_count,
    output logic [31:0]           wr_count
);
    localparam int         IDX_W    = $clog2(DEPTH);
    localparam logic [3:0] LAT_LAST = 4'(LATENCY - 1);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t                state, state_nxt;
    logic [3:0]            wait_cnt, wait_cnt_nxt;
    logic [ADDR_WIDTH-1:0] addr_q, in_off, b_off;
    logic [DATA_WIDTH-1:0] wdata_q, b_wdata;
    logic                  op_wr_q, addr_err_q;
    logic                  req, accept, enter_resp, in_err, b_wr, b_err;
    logic [IDX_W-1:0]      b_idx;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    assign req        = bus.mem_read | bus.mem_write;
    assign accept     = (state == IDLE) && req;
    assign enter_resp = (state_nxt == RESP);
    assign in_off     = bus.mem_addr - BASE_ADDR;
    assign in_err     = (bus.mem_addr[1:0] != 2'b00) || (bus.mem_addr < BASE_ADDR) ||
                        ((in_off >> (IDX_W + 2)) != '0);
    // With zero latency the beat reaches RESP on the accept edge, so bypass the request latches
    assign b_wr    = (state == IDLE) ? bus.mem_write : op_wr_q;
    assign b_err   = (state == IDLE) ? in_err : addr_err_q;
    assign b_wdata = (state == IDLE) ? bus.mem_wdata : wdata_q;
    assign b_off   = ((state == IDLE) ? bus.mem_addr : addr_q) - BASE_ADDR;
    assign b_idx   = IDX_W'(b_off >> 2);
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        case (state)
            IDLE: begin
                if (req) begin
                    state_nxt    = (LATENCY > 0) ? WAIT : RESP;
                    wait_cnt_nxt = '0;
                end
            end
            WAIT: begin
                if (!req) state_nxt = IDLE;
                else if (wait_cnt == LAT_LAST) state_nxt = RESP;
                else wait_cnt_nxt = wait_cnt + 4'd1;
            end
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            wait_cnt      <= '0;
            addr_q        <= '0;
            wdata_q       <= '0;
            op_wr_q       <= 1'b0;
            addr_err_q    <= 1'b0;
            bus.mem_ready <= 1'b0;
            bus.mem_rdata <= '0;
            err           <= 1'b0;
            err_addr      <= '0;
            rd_count      <= '0;
            wr_count      <= '0;
        end else begin
            state         <= state_nxt;
            wait_cnt      <= wait_cnt_nxt;
            bus.mem_ready <= enter_resp;
            if (accept) begin
                addr_q     <= bus.mem_addr;
                wdata_q    <= bus.mem_wdata;
                op_wr_q    <= bus.mem_write;
                addr_err_q <= in_err;
            end
            if (enter_resp && !b_wr) bus.mem_rdata <= b_err ? '0 : mem[b_idx];
            if (enter_resp && !b_err && b_wr) wr_count <= wr_count + 32'd1;
            if (enter_resp && !b_err && !b_wr) rd_count <= rd_count + 32'd1;
            if (err_clr) begin
                err      <= 1'b0;
                err_addr <= '0;
            end else if (accept && !err && (in_err || (bus.mem_read && bus.mem_write))) begin
                err      <= 1'b1;
                err_addr <= bus.mem_addr;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst_n && enter_resp && b_wr && !b_err) mem[b_idx] <= b_wdata;
    end
endmodule

// File: tb/tb_tpu_mem_responder.sv
// tb_tpu_mem_responder: directed and randomized beats checked against a beat-level scratchpad model
module tb_tpu_mem_responder;
    localparam int          LAT   = 2;
    localparam int          DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h1000_0000;
    localparam logic [31:0] TOP   = BASE + DEPTH * 4;
    logic        clk     = 1'b0;
    logic        rst_n   = 1'b0;
    logic        err_clr = 1'b0;
    logic        err;
    logic [31:0] err_addr, rd_count, wr_count;
    int          checks = 0, passed = 0, fails = 0, cyc = 0;
    logic [31:0] ref_mem [int];
    logic [31:0] m_rd = 0, m_wr = 0, m_err_addr = 0;
    logic        m_err = 1'b0;
    tpu_mem_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();
    tpu_mem_responder #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(DEPTH), .BASE_ADDR(BASE), .LATENCY(LAT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .err_clr(err_clr), .err(err),
        .err_addr(err_addr), .rd_count(rd_count), .wr_count(wr_count)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed hang expected completion");
        $fatal(1, "watchdog");
    end
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask
    function automatic bit addr_ok(input logic [31:0] a);
        return a[1:0] == 2'b00 && a >= BASE && a < TOP;
    endfunction
    task automatic check_status(input string tag);
        check({tag, "/err"}, 32'(err), 32'(m_err));
        check({tag, "/err_addr"}, err_addr, m_err_addr);
        check({tag, "/rd_count"}, rd_count, m_rd);
        check({tag, "/wr_count"}, wr_count, m_wr);
    endtask
    // One complete beat: request held through the wait, inputs scrambled after accept
    task automatic beat(input string tag, input bit rd, input bit wr, input logic [31:0] a,
                        input logic [31:0] d, input bit clr);
        int          t0, lat, idx;
        logic [31:0] got;
        bit          seen, known;
        lat = -1;
        got = '0;
        seen = 0;
        @(negedge clk);
        bus.mem_read = rd; bus.mem_write = wr; bus.mem_addr = a; bus.mem_wdata = d; err_clr = clr;
        @(posedge clk);
        #1;
        t0 = cyc;
        err_clr = 1'b0;
        bus.mem_addr = $urandom;
        bus.mem_wdata = $urandom;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (bus.mem_ready) begin
                seen = 1;
                lat = cyc - t0;
                got = bus.mem_rdata;
            end else begin
                @(posedge clk);
                #1;
            end
        end
        bus.mem_read = 1'b0;
        bus.mem_write = 1'b0;
        idx = int'((a - BASE) >> 2);
        known = addr_ok(a) && ref_mem.exists(idx);
        if (clr) begin
            m_err = 1'b0;
            m_err_addr = '0;
        end else if (!m_err && (!addr_ok(a) || (rd && wr))) begin
            m_err = 1'b1;
            m_err_addr = a;
        end
        if (wr) begin
            if (addr_ok(a)) begin
                ref_mem[idx] = d;
                m_wr++;
            end
        end else if (addr_ok(a)) m_rd++;
        check({tag, "/latency"}, 32'(lat), 32'(LAT));
        if (!wr && !addr_ok(a)) check({tag, "/rdata"}, got, 32'h0);
        else if (!wr && known) check({tag, "/rdata"}, got, ref_mem[idx]);
        @(posedge clk);
        #1;
        check({tag, "/pulse"}, 32'(bus.mem_ready), 32'h0);
        check_status(tag);
    endtask
    task automatic no_ready(input string tag, input int n);
        bit seen;
        seen = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (bus.mem_ready) seen = 1;
        end
        check({tag, "/no_ready"}, 32'(seen), 32'h0);
    endtask
    initial begin
        int          prev;
        bit          seen;
        logic [31:0] a;
        int          sel, op;
        bus.mem_read = 1'b0; bus.mem_write = 1'b0; bus.mem_addr = '0; bus.mem_wdata = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("reset/ready", 32'(bus.mem_ready), 32'h0);
        check("reset/rdata", bus.mem_rdata, 32'h0);
        check_status("reset");
        beat("wr_base", 0, 1, BASE, 32'hCAFE_F00D, 0);
        beat("rd_base", 1, 0, BASE, 32'h0, 0);
        beat("wr_w1", 0, 1, BASE + 4, 32'h1111_0001, 0);
        beat("wr_w2", 0, 1, BASE + 8, 32'h1111_0002, 0);
        beat("wr_w3", 0, 1, BASE + 12, 32'h1111_0003, 0);
        @(negedge clk);
        bus.mem_read = 1'b1;
        bus.mem_addr = BASE;
        prev = 0;
        for (int b = 0; b < 4; b++) begin
            seen = 0;
            for (int i = 0; i < 20 && !seen; i++) begin
                @(posedge clk);
                #1;
                if (bus.mem_ready) seen = 1;
            end
            check("held/seen", 32'(seen), 32'h1);
            check("held/data", bus.mem_rdata, ref_mem[b]);
            if (b > 0) check("held/gap", 32'(cyc - prev), 32'(2 + LAT));
            prev = cyc;
            m_rd++;
            bus.mem_addr = bus.mem_addr + 32'd4;
        end
        bus.mem_read = 1'b0;
        @(posedge clk);
        #1;
        check_status("held");
        beat("wr_last", 0, 1, TOP - 4, 32'hDEAD_BEEF, 0);
        beat("rd_last", 1, 0, TOP - 4, 32'h0, 0);
        beat("rd_oob", 1, 0, 32'h1000_1000, 32'h0, 0);
        beat("wr_misalign", 0, 1, BASE + 2, 32'h5555_5555, 0);
        beat("rd_below", 1, 0, BASE - 4, 32'h0, 0);
        beat("rd_w2_intact", 1, 0, BASE + 8, 32'h0, 0);
        @(negedge clk);
        bus.mem_write = 1'b1; bus.mem_addr = BASE + 8; bus.mem_wdata = 32'h2222_2222;
        @(posedge clk);
        #1;
        bus.mem_write = 1'b0;
        no_ready("abort", 8);
        check_status("abort");
        beat("abort_rd", 1, 0, BASE + 8, 32'h0, 0);
        @(negedge clk);
        bus.mem_write = 1'b1; bus.mem_addr = BASE + 12; bus.mem_wdata = 32'h3333_3333;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        m_rd = 0; m_wr = 0; m_err = 1'b0; m_err_addr = '0;
        check("midrst/ready", 32'(bus.mem_ready), 32'h0);
        check("midrst/rdata", bus.mem_rdata, 32'h0);
        check_status("midrst");
        @(negedge clk);
        bus.mem_write = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        no_ready("midrst", 6);
        beat("midrst_rd", 1, 0, BASE + 12, 32'h0, 0);
        beat("proto", 1, 1, BASE + 16, 32'h7777_0016, 0);
        beat("proto_rd", 1, 0, BASE + 16, 32'h0, 0);
        beat("proto2_first_only", 1, 1, BASE + 20, 32'h7777_0020, 0);
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        m_err = 1'b0;
        m_err_addr = '0;
        check_status("clr");
        beat("proto_clr", 1, 1, BASE + 24, 32'h7777_0024, 1);
        beat("oob_clr", 1, 0, TOP, 32'h0, 1);
        beat("oob_after_clr", 0, 1, TOP + 8, 32'h1234_5678, 0);
        for (int n = 0; n < 60; n++) begin
            sel = $urandom_range(0, 9);
            a = BASE + 4 * $urandom_range(0, 15);
            if (sel == 0) a = TOP + 4 * $urandom_range(0, 15);
            else if (sel == 1) a = a + 32'($urandom_range(1, 3));
            else if (sel == 2) a = BASE - 4 * $urandom_range(1, 4);
            else if (sel == 3) a = TOP - 4;
            op = $urandom_range(0, 5);
            beat("rand", op == 0 || op > 2, op < 3, a, $urandom, $urandom_range(0, 9) == 0);
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
